// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI bus arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_t;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_FETCH  = 2'd0;
  localparam logic [1:0] REQ_LS     = 2'd1;
  localparam logic [1:0] REQ_PERIPH = 2'd2;

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational three-way round-robin picker
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [2:0] gnt
);

  // Search starts at the requester after last_grant and wraps around.
  always_comb begin
    gnt = 3'b000;
    case (last_grant)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - shares one SPI controller between fetch, load/store and peripheral
module spi_bus_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_write,
  input  logic [31:0]       ls_wdata,
  input  logic [2:0]        ls_num_bytes,
  input  logic              pr_req,
  input  logic [7:0]        pr_tx_byte,
  output logic [2:0]        rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              ctl_start,
  input  logic              ctl_done,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic              ctl_write,
  output logic [31:0]       ctl_wdata,
  output logic [2:0]        ctl_num_bytes,
  output logic              ctl_is_periph,
  output logic [7:0]        ctl_tx_byte,
  input  logic [31:0]       ctl_fetched_value,
  output logic              flash_cs_n,
  output logic              ram_cs_n,
  output logic              periph_cs_n
);
  import spi_arb_pkg::*;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t          state, state_next;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt;
  logic [1:0]          grant, last_grant;
  logic [7:0]          tmo_cnt;
  logic                tmo_hit;
  logic [2:0]          cs_n;

  logic [1:0]          win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_write;
  logic [31:0]         win_wdata;
  logic [2:0]          win_num;
  logic                win_periph;
  logic [7:0]          win_tx;
  logic [2:0]          win_cs_n;

  assign req     = {pr_req, ls_req, if_req};
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign flash_cs_n  = cs_n[0];
  assign ram_cs_n    = cs_n[1];
  assign periph_cs_n = cs_n[2];

  rr_arbiter3 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_comb begin
    win_idx    = REQ_FETCH;
    win_addr   = if_addr;
    win_write  = 1'b0;
    win_wdata  = '0;
    win_num    = 3'd4;
    win_periph = 1'b0;
    win_tx     = '0;
    if (gnt[REQ_LS]) begin
      win_idx   = REQ_LS;
      win_addr  = ls_addr;
      win_write = ls_write;
      win_wdata = ls_wdata;
      win_num   = ls_num_bytes;
    end else if (gnt[REQ_PERIPH]) begin
      win_idx    = REQ_PERIPH;
      win_addr   = '0;
      win_num    = 3'd1;
      win_periph = 1'b1;
      win_tx     = pr_tx_byte;
    end
  end

  // cs_n bit order: {periph, ram, flash}; address MSB picks RAM over flash.
  always_comb begin
    if (win_periph)                win_cs_n = 3'b011;
    else if (win_addr[ADDR_W-1])   win_cs_n = 3'b101;
    else                           win_cs_n = 3'b110;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (|gnt) state_next = ST_START;
      ST_START:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ctl_done || tmo_hit) state_next = ST_GAP;
      ST_GAP:       state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= REQ_FETCH;
      last_grant    <= REQ_PERIPH;
      tmo_cnt       <= '0;
      cs_n          <= 3'b111;
      ctl_start     <= 1'b0;
      ctl_addr      <= '0;
      ctl_write     <= 1'b0;
      ctl_wdata     <= '0;
      ctl_num_bytes <= '0;
      ctl_is_periph <= 1'b0;
      ctl_tx_byte   <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            grant         <= win_idx;
            cs_n          <= win_cs_n;
            ctl_addr      <= win_addr;
            ctl_write     <= win_write;
            ctl_wdata     <= win_wdata;
            ctl_num_bytes <= win_num;
            ctl_is_periph <= win_periph;
            ctl_tx_byte   <= win_tx;
          end
        end
        ST_START: begin
          ctl_start <= 1'b1;
          tmo_cnt   <= '0;
        end
        ST_WAIT_DONE: begin
          // A done arriving on the timeout cycle still counts as success.
          if (ctl_done || tmo_hit) begin
            rsp_data   <= ctl_done ? ctl_fetched_value : 32'd0;
            rsp_err    <= ~ctl_done;
            rsp_valid  <= 3'b001 << grant;
            ctl_start  <= 1'b0;
            cs_n       <= 3'b111;
            last_grant <= grant;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - self-checking bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_write, pr_req, ctl_done;
  logic [15:0] if_addr, ls_addr;
  logic [31:0] ls_wdata, ctl_fetched_value;
  logic [2:0]  ls_num_bytes;
  logic [7:0]  pr_tx_byte;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err, ctl_start, ctl_write, ctl_is_periph;
  logic [15:0] ctl_addr;
  logic [31:0] ctl_wdata;
  logic [2:0]  ctl_num_bytes;
  logic [7:0]  ctl_tx_byte;
  logic        flash_cs_n, ram_cs_n, periph_cs_n;
  wire  [2:0]  cs_vec = {periph_cs_n, ram_cs_n, flash_cs_n};

  int checks = 0;
  int errors = 0;
  int m_last;

  logic [15:0] o_addr;
  logic        o_write, o_periph, o_err, o_stable, o_post_start;
  logic [31:0] o_wdata, o_data;
  logic [2:0]  o_num, o_cs, o_cs_before, o_valid, o_post_cs;
  logic [7:0]  o_tx;
  int          o_gap, o_wait;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.ADDR_W(16), .TIMEOUT_CYCLES(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_write(ls_write), .ls_wdata(ls_wdata),
    .ls_num_bytes(ls_num_bytes),
    .pr_req(pr_req), .pr_tx_byte(pr_tx_byte),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ctl_start(ctl_start), .ctl_done(ctl_done), .ctl_addr(ctl_addr),
    .ctl_write(ctl_write), .ctl_wdata(ctl_wdata), .ctl_num_bytes(ctl_num_bytes),
    .ctl_is_periph(ctl_is_periph), .ctl_tx_byte(ctl_tx_byte),
    .ctl_fetched_value(ctl_fetched_value),
    .flash_cs_n(flash_cs_n), .ram_cs_n(ram_cs_n), .periph_cs_n(periph_cs_n)
  );

  // Reference model: next pending requester after the last one served.
  function automatic int rr_pick(input logic [2:0] mask, input int last);
    for (int k = 1; k <= 3; k++)
      if (mask[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] exp_cs(input int idx, input logic [15:0] a);
    if (idx == 2) return 3'b011;
    return a[15] ? 3'b101 : 3'b110;
  endfunction

  function automatic int onehot_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  // Controller stand-in: waits for start, holds for delay cycles, then answers (or never answers).
  task automatic serve(input logic [31:0] val, input int delay, input bit hang, output bit ok);
    int n;
    ok = 1'b1;
    o_stable = 1'b1;
    o_gap = 0;
    o_cs_before = 3'b111;
    while (ctl_start !== 1'b1 && o_gap < 40) begin
      o_cs_before = cs_vec;
      @(negedge clk);
      o_gap++;
    end
    if (ctl_start !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    o_addr = ctl_addr; o_write = ctl_write; o_wdata = ctl_wdata; o_num = ctl_num_bytes;
    o_periph = ctl_is_periph; o_tx = ctl_tx_byte; o_cs = cs_vec;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (cs_vec !== o_cs || ctl_start !== 1'b1 || rsp_valid !== 3'b000) o_stable = 1'b0;
    end
    if (!hang) begin
      ctl_fetched_value = val;
      ctl_done = 1'b1;
      @(negedge clk);
      ctl_done = 1'b0;
    end
    n = 0;
    while (rsp_valid === 3'b000 && n < 300) begin
      @(negedge clk);
      n++;
    end
    o_wait = n; o_valid = rsp_valid; o_data = rsp_data; o_err = rsp_err;
    o_post_cs = cs_vec; o_post_start = ctl_start;
    if (rsp_valid === 3'b000) ok = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ctl_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", ctl_start); end
    checks++; if (cs_vec !== 3'b111) begin errors++; $display("FAIL reset_cs got %b want 111", cs_vec); end
    checks++; if (rsp_valid !== 3'b000 || rsp_err !== 1'b0 || rsp_data !== 32'd0) begin
      errors++; $display("FAIL reset_rsp got %b/%b/%h want 000/0/00000000", rsp_valid, rsp_err, rsp_data); end
    checks++; if (ctl_addr !== 16'd0 || ctl_num_bytes !== 3'd0 || ctl_wdata !== 32'd0 || ctl_is_periph !== 1'b0
                  || ctl_write !== 1'b0 || ctl_tx_byte !== 8'd0) begin
      errors++; $display("FAIL reset_ops got addr %h num %0d want 0", ctl_addr, ctl_num_bytes); end
    rst_n = 1'b1;
    m_last = 2;
    repeat (2) @(negedge clk);
    checks++; if (ctl_start !== 1'b0 || cs_vec !== 3'b111) begin
      errors++; $display("FAIL idle_quiet got start %b cs %b want 0 111", ctl_start, cs_vec); end
  endtask

  task automatic test_single_fetch;
    bit ok;
    if_addr = 16'h0010; if_req = 1'b1;
    serve(32'hDEADBEEF, 3, 1'b0, ok);
    if_req = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fetch_handshake got %b want 1", ok); end
    checks++; if (o_cs !== 3'b110 || o_cs_before !== 3'b110) begin
      errors++; $display("FAIL fetch_cs got %b (before %b) want 110", o_cs, o_cs_before); end
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL fetch_cs_stable got %b want 1", o_stable); end
    checks++; if (o_num !== 3'd4 || o_write !== 1'b0 || o_periph !== 1'b0 || o_addr !== 16'h0010) begin
      errors++; $display("FAIL fetch_ops got num %0d wr %b per %b addr %h want 4 0 0 0010", o_num, o_write, o_periph, o_addr); end
    checks++; if (o_valid !== 3'b001 || o_data !== 32'hDEADBEEF || o_err !== 1'b0) begin
      errors++; $display("FAIL fetch_rsp got %b %h %b want 001 deadbeef 0", o_valid, o_data, o_err); end
    checks++; if (o_wait !== 0) begin errors++; $display("FAIL fetch_rsp_latency got %0d want 0", o_wait); end
    checks++; if (o_post_cs !== 3'b111 || o_post_start !== 1'b0) begin
      errors++; $display("FAIL fetch_release got cs %b start %b want 111 0", o_post_cs, o_post_start); end
    @(negedge clk);
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL fetch_pulse_width got %b want 000", rsp_valid); end
    m_last = 0;
  endtask

  task automatic test_ram_store;
    bit ok;
    logic [31:0] v;
    v = $urandom;
    ls_addr = 16'h8004; ls_write = 1'b1; ls_wdata = 32'h11223344; ls_num_bytes = 3'd2; ls_req = 1'b1;
    serve(v, $urandom_range(0, 5), 1'b0, ok);
    ls_req = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL store_handshake got %b want 1", ok); end
    checks++; if (o_cs !== 3'b101) begin errors++; $display("FAIL store_cs got %b want 101", o_cs); end
    checks++; if (o_wdata !== 32'h11223344 || o_write !== 1'b1 || o_num !== 3'd2 || o_addr !== 16'h8004) begin
      errors++; $display("FAIL store_ops got %h %b %0d %h want 11223344 1 2 8004", o_wdata, o_write, o_num, o_addr); end
    checks++; if (o_valid !== 3'b010 || o_data !== v || o_err !== 1'b0) begin
      errors++; $display("FAIL store_rsp got %b %h %b want 010 %h 0", o_valid, o_data, o_err, v); end
    m_last = 1;
  endtask

  task automatic test_periph;
    bit ok;
    pr_tx_byte = 8'hA5; pr_req = 1'b1;
    serve(32'h0000003C, 2, 1'b0, ok);
    pr_req = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL periph_handshake got %b want 1", ok); end
    checks++; if (o_cs !== 3'b011 || o_periph !== 1'b1 || o_tx !== 8'hA5 || o_num !== 3'd1) begin
      errors++; $display("FAIL periph_ops got cs %b per %b tx %h num %0d want 011 1 a5 1", o_cs, o_periph, o_tx, o_num); end
    checks++; if (o_valid !== 3'b100 || o_data[7:0] !== 8'h3C || o_err !== 1'b0) begin
      errors++; $display("FAIL periph_rsp got %b %h %b want 100 3c 0", o_valid, o_data[7:0], o_err); end
    m_last = 2;
  endtask

  task automatic test_timeout;
    bit ok;
    if_addr = 16'h0100; if_req = 1'b1;
    serve(32'h0, 0, 1'b1, ok);
    if_req = 1'b0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout_handshake got %b want 1", ok); end
    checks++; if (o_wait !== 128) begin errors++; $display("FAIL timeout_cycles got %0d want 128", o_wait); end
    checks++; if (o_valid !== 3'b001 || o_err !== 1'b1 || o_data !== 32'd0) begin
      errors++; $display("FAIL timeout_rsp got %b %b %h want 001 1 00000000", o_valid, o_err, o_data); end
    checks++; if (o_post_cs !== 3'b111 || o_post_start !== 1'b0) begin
      errors++; $display("FAIL timeout_release got cs %b start %b want 111 0", o_post_cs, o_post_start); end
    m_last = 0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [2:0] mask;
    logic [31:0] v;
    int exp_idx;
    for (int i = 0; i < 26; i++) begin
      mask = (i < 6) ? 3'b111 : 3'($urandom_range(1, 7));
      if (i == 0 || i >= 6) begin
        if_addr = 16'($urandom); ls_addr = 16'($urandom); ls_write = 1'($urandom);
        ls_wdata = $urandom; ls_num_bytes = 3'($urandom); pr_tx_byte = 8'($urandom);
      end
      {pr_req, ls_req, if_req} = mask;
      exp_idx = rr_pick(mask, m_last);
      v = $urandom;
      serve(v, $urandom_range(0, 4), 1'b0, ok);
      checks++; if (ok !== 1'b1 || onehot_idx(o_valid) != exp_idx) begin
        errors++; $display("FAIL rr_grant[%0d] got %0d want %0d (mask %b)", i, onehot_idx(o_valid), exp_idx, mask); end
      checks++; if (o_cs !== exp_cs(exp_idx, exp_idx == 0 ? if_addr : ls_addr)) begin
        errors++; $display("FAIL rr_cs[%0d] got %b want %b", i, o_cs, exp_cs(exp_idx, exp_idx == 0 ? if_addr : ls_addr)); end
      checks++; if (o_num !== (exp_idx == 0 ? 3'd4 : exp_idx == 1 ? ls_num_bytes : 3'd1)
                    || o_addr !== (exp_idx == 0 ? if_addr : exp_idx == 1 ? ls_addr : o_addr)) begin
        errors++; $display("FAIL rr_ops[%0d] got num %0d addr %h", i, o_num, o_addr); end
      checks++; if (o_data !== v || o_err !== 1'b0 || o_stable !== 1'b1) begin
        errors++; $display("FAIL rr_rsp[%0d] got %h err %b stable %b want %h 0 1", i, o_data, o_err, o_stable, v); end
      if (i > 0) begin
        checks++; if (o_gap !== 3) begin errors++; $display("FAIL rr_turnaround[%0d] got %0d want 3", i, o_gap); end
      end
      if (exp_idx >= 0) m_last = exp_idx;
    end
    {pr_req, ls_req, if_req} = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    if_addr = 16'h0040; ls_addr = 16'h8000; if_req = 1'b1;
    n = 0;
    while (ctl_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++; if (ctl_start !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", ctl_start); end
    rst_n = 1'b0;
    #1;
    checks++; if (ctl_start !== 1'b0 || cs_vec !== 3'b111 || rsp_valid !== 3'b000) begin
      errors++; $display("FAIL rstmid_async got start %b cs %b valid %b want 0 111 000", ctl_start, cs_vec, rsp_valid); end
    ls_req = 1'b1; pr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rstmid_no_rsp got %b want 000", rsp_valid); end
    end
    rst_n = 1'b1;
    m_last = 2;
    serve(32'hCAFEF00D, 1, 1'b0, ok);
    checks++; if (ok !== 1'b1 || o_valid !== 3'b001 || o_cs !== 3'b110) begin
      errors++; $display("FAIL rstmid_first_grant got valid %b cs %b want 001 110", o_valid, o_cs); end
    {pr_req, ls_req, if_req} = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; pr_req = 1'b0; ctl_done = 1'b0;
    if_addr = '0; ls_addr = '0; ls_write = 1'b0; ls_wdata = '0; ls_num_bytes = '0;
    pr_tx_byte = '0; ctl_fetched_value = '0;
    m_last = 2;
    test_reset;
    test_single_fetch;
    test_ram_store;
    test_periph;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
